// File: rtl/systolic_feeder.sv
// systolic_feeder: operand feeder for one row of the MAC systolic array.
// Buffers {a, b, last} vector pairs in a FIFO, feeds them into a lane-skewed
// pipeline (lane i delayed by i cycles) and, after the last vector of a job,
// flushes zeros until every lane has drained, then pulses done.
// Optional feature: define FEEDER_UNDERRUN_CNT_EN to enable the saturating
// FEED-state bubble counter on underrun_cnt (tied to 0 otherwise).
module systolic_feeder #(
  parameter int LANES = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] in_a,
  input  logic [LANES*DW-1:0] in_b,
  input  logic                in_last,
  output logic [LANES*DW-1:0] out_a,
  output logic [LANES*DW-1:0] out_b,
  output logic [LANES-1:0]    out_valid,
  output logic                busy,
  output logic                done,
  output logic [7:0]          underrun_cnt
);

  localparam int VW = LANES * DW;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = 2 * VW + 1;
  localparam int FW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_FLUSH, S_DONE} state_t;

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q, state_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic [VW-1:0] a_p0_q, a_p0_d, b_p0_q, b_p0_d;
  logic          vld_p0_q, vld_p0_d;
  logic          push, pop, fifo_empty;
  logic [EW-1:0] head;

  // in_ready comes only from the registered count; a same-cycle pop cannot raise it
  assign in_ready = (count_q != CW'(DEPTH));

  // FIFO bookkeeping, FSM next state and stage-0 operand selection
  always_comb begin
    push       = in_valid && in_ready;
    fifo_empty = (count_q == '0);
    head       = mem_q[rd_ptr_q];
    pop        = (state_q == S_FEED) && !fifo_empty;

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = {in_a, in_b, in_last};
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);

    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    a_p0_d      = '0;
    b_p0_d      = '0;
    vld_p0_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) state_d = S_FEED;
      end
      S_FEED: begin
        // an empty FIFO here is an underrun: zeros with valid=0 keep the skew aligned
        if (!fifo_empty) begin
          a_p0_d   = head[EW-1 -: VW];
          b_p0_d   = head[VW:1];
          vld_p0_d = 1'b1;
          if (head[0]) begin
            state_d     = S_FLUSH;
            flush_cnt_d = FW'(LANES - 1);
          end
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == '0) state_d = S_DONE;
        else                   flush_cnt_d = flush_cnt_q - FW'(1);
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // FIFO, FSM and stage-0 registers; reset empties everything immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      flush_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      a_p0_q      <= '0;
      b_p0_q      <= '0;
      vld_p0_q    <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      a_p0_q      <= a_p0_d;
      b_p0_q      <= b_p0_d;
      vld_p0_q    <= vld_p0_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  // ---- stage 0 -> skew: lane i sees stage 0 after i more registers ----
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    if (i == 0) begin : g_direct
      assign out_a[DW-1:0] = a_p0_q[DW-1:0];
      assign out_b[DW-1:0] = b_p0_q[DW-1:0];
      assign out_valid[0]  = vld_p0_q;
    end else begin : g_skew
      localparam int SW = i * DW;
      localparam int SV = i;
      logic [SW-1:0] sa_q, sa_d, sb_q, sb_d;
      logic [SV-1:0] sv_q, sv_d;

      // shift the lane's slice in at the bottom; the oldest sample sits at the top
      always_comb begin
        sa_d = SW'({sa_q, a_p0_q[i*DW +: DW]});
        sb_d = SW'({sb_q, b_p0_q[i*DW +: DW]});
        sv_d = SV'({sv_q, vld_p0_q});
      end

      // skew delay registers for a, b and valid together
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sa_q <= '0;
          sb_q <= '0;
          sv_q <= '0;
        end else begin
          sa_q <= sa_d;
          sb_q <= sb_d;
          sv_q <= sv_d;
        end
      end

      assign out_a[i*DW +: DW] = sa_q[SW-1 -: DW];
      assign out_b[i*DW +: DW] = sb_q[SW-1 -: DW];
      assign out_valid[i]      = sv_q[SV-1];
    end
  end

`ifdef FEEDER_UNDERRUN_CNT_EN
  logic [7:0] under_q, under_d;

  // count FEED-state bubbles, saturating at 255
  always_comb begin
    under_d = under_q;
    if ((state_q == S_FEED) && fifo_empty && (under_q != 8'hFF)) under_d = under_q + 8'd1;
  end

  // underrun counter register, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) under_q <= 8'd0;
    else      under_q <= under_d;
  end

  assign underrun_cnt = under_q;
`else
  assign underrun_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Testbench for systolic_feeder: directed scenarios plus randomized traffic,
// checked against a queue-based reference model of the feeder behaviour.
`timescale 1ns/1ps
module tb_systolic_feeder;
  localparam int LANES = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int VW    = LANES * DW;

  localparam int P_IDLE  = 0;
  localparam int P_FEED  = 1;
  localparam int P_FLUSH = 2;
  localparam int P_DONE  = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [VW-1:0]   in_a = '0;
  logic [VW-1:0]   in_b = '0;
  logic            in_last = 1'b0;
  logic [VW-1:0]   out_a, out_b;
  logic [LANES-1:0] out_valid;
  logic            busy, done;
  logic [7:0]      underrun_cnt;

  systolic_feeder #(.LANES(LANES), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_a(out_a), .out_b(out_b), .out_valid(out_valid),
    .busy(busy), .done(done), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;

  // reference model: job queue, phase of the job, and a per-cycle stage-0 history
  typedef struct packed {
    logic [VW-1:0] a;
    logic [VW-1:0] b;
    logic          last;
  } ent_t;
  ent_t          mq[$];
  int            phase;
  int            flush_left;
  int            mund;
  logic [VW-1:0] hist_a [LANES];
  logic [VW-1:0] hist_b [LANES];
  logic          hist_v [LANES];

  logic [VW-1:0]    e_a, e_b;
  logic [LANES-1:0] e_v;
  logic             e_rdy, e_busy, e_done;
  logic [7:0]       e_und;

  task automatic model_outs();
    e_a = '0; e_b = '0; e_v = '0;
    for (int i = 0; i < LANES; i++) begin
      e_a[i*DW +: DW] = hist_a[i][i*DW +: DW];
      e_b[i*DW +: DW] = hist_b[i][i*DW +: DW];
      e_v[i]          = hist_v[i];
    end
    e_rdy  = (mq.size() != DEPTH);
    e_busy = (phase != P_IDLE);
    e_done = (phase == P_DONE);
`ifdef FEEDER_UNDERRUN_CNT_EN
    e_und = 8'(mund);
`else
    e_und = 8'd0;
`endif
  endtask

  task automatic model_reset();
    mq.delete();
    phase = P_IDLE; flush_left = 0; mund = 0;
    for (int i = 0; i < LANES; i++) begin
      hist_a[i] = '0; hist_b[i] = '0; hist_v[i] = 1'b0;
    end
    model_outs();
  endtask

  task automatic model_step();
    int            sz;
    logic          acc;
    ent_t          e;
    logic [VW-1:0] na, nb;
    logic          nv;
    sz  = mq.size();
    acc = in_valid && (sz != DEPTH);
    na = '0; nb = '0; nv = 1'b0;
    case (phase)
      P_IDLE: if (sz != 0) phase = P_FEED;
      P_FEED: begin
        if (sz != 0) begin
          e = mq.pop_front();
          na = e.a; nb = e.b; nv = 1'b1;
          if (e.last) begin phase = P_FLUSH; flush_left = LANES; end
        end else if (mund < 255) mund++;
      end
      P_FLUSH: begin
        flush_left--;
        if (flush_left == 0) phase = P_DONE;
      end
      default: phase = P_IDLE;
    endcase
    for (int i = LANES - 1; i > 0; i--) begin
      hist_a[i] = hist_a[i-1]; hist_b[i] = hist_b[i-1]; hist_v[i] = hist_v[i-1];
    end
    hist_a[0] = na; hist_b[0] = nb; hist_v[0] = nv;
    if (acc) mq.push_back('{a: in_a, b: in_b, last: in_last});
  endtask

  // one clock: advance the model with the inputs the DUT saw, then settle
  task automatic cyc();
    @(posedge clk);
    cyc_n++;
    if (!rst) model_reset();
    else      model_step();
    #1;
    model_outs();
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0;
    model_reset();
    repeat (3) cyc();
    checks++;
    if (out_a !== '0 || out_b !== '0 || out_valid !== '0 || busy !== 1'b0 || done !== 1'b0 ||
        underrun_cnt !== 8'd0 || in_ready !== 1'b1)
      begin failures++; $display("FAIL reset_init a=%h b=%h v=%b busy=%b done=%b und=%0d rdy=%b, want zeros and rdy=1",
                                 out_a, out_b, out_valid, busy, done, underrun_cnt, in_ready); end
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_a = VW'($urandom); in_b = VW'($urandom); in_last = (k == 5);
      cyc();
      checks++;
      if (out_a !== e_a || out_b !== e_b || out_valid !== e_v || in_ready !== e_rdy || busy !== e_busy || done !== e_done)
        begin failures++; $display("FAIL reset_traffic cyc=%0d a=%h/%h b=%h/%h v=%b/%b rbd=%b%b%b/%b%b%b",
                                   cyc_n, out_a, e_a, out_b, e_b, out_valid, e_v, in_ready, busy, done, e_rdy, e_busy, e_done); end
    end
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (out_a !== '0 || out_b !== '0 || out_valid !== '0 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1)
      begin failures++; $display("FAIL reset_async a=%h b=%h v=%b busy=%b done=%b rdy=%b, want zeros and rdy=1",
                                 out_a, out_b, out_valid, busy, done, in_ready); end
    in_valid = 1'b0;
    cyc();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== '0)
        begin failures++; $display("FAIL reset_idle busy=%b rdy=%b v=%b, want 0 1 0000", busy, in_ready, out_valid); end
    end
  endtask

  task automatic test_single_job();
    in_valid = 1'b1; in_a = 32'h04030201; in_b = 32'h08070605; in_last = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      cyc();
      in_valid = 1'b0;
      checks++;
      if (out_a !== e_a || out_b !== e_b || out_valid !== e_v || in_ready !== e_rdy || busy !== e_busy || done !== e_done)
        begin failures++; $display("FAIL single_model c=%0d a=%h/%h b=%h/%h v=%b/%b rbd=%b%b%b/%b%b%b",
                                   c, out_a, e_a, out_b, e_b, out_valid, e_v, in_ready, busy, done, e_rdy, e_busy, e_done); end
      checks++;
      if (busy !== 1'((c >= 2) && (c <= 7)) || done !== 1'(c == 7))
        begin failures++; $display("FAIL single_busy_done c=%0d busy=%b done=%b", c, busy, done); end
      if (c >= 3 && c <= 6) begin
        checks++;
        if (out_valid !== 4'(1 << (c - 3)) || out_a[(c-3)*DW +: DW] !== 8'(c - 2) || out_b[(c-3)*DW +: DW] !== 8'(c + 2))
          begin failures++; $display("FAIL single_lane c=%0d v=%b a=%h b=%h want v=%b a=%0d b=%0d",
                                     c, out_valid, out_a, out_b, 4'(1 << (c - 3)), c - 2, c + 2); end
      end else begin
        checks++;
        if (out_valid !== '0) begin failures++; $display("FAIL single_novalid c=%0d v=%b want 0000", c, out_valid); end
      end
    end
  endtask

  task automatic test_full();
    logic acc;
    in_valid = 1'b1; in_a = VW'($urandom); in_b = VW'($urandom); in_last = 1'b1;
    cyc();
    for (int n = 0; n < 10; n++) begin
      in_valid = 1'b1; in_a = VW'($urandom); in_b = VW'($urandom); in_last = (n == 9);
      acc = 1'b0;
      for (int w = 0; w < 20 && !acc; w++) begin
        acc = in_ready;
        if (n == 8 && w == 0) begin
          checks++;
          if (in_ready !== 1'b0) begin failures++; $display("FAIL full_ready_low rdy=%b want 0", in_ready); end
        end
        cyc();
        checks++;
        if (out_a !== e_a || out_b !== e_b || out_valid !== e_v || in_ready !== e_rdy || busy !== e_busy || done !== e_done)
          begin failures++; $display("FAIL full_model cyc=%0d a=%h/%h b=%h/%h v=%b/%b rbd=%b%b%b/%b%b%b",
                                     cyc_n, out_a, e_a, out_b, e_b, out_valid, e_v, in_ready, busy, done, e_rdy, e_busy, e_done); end
      end
      checks++;
      if (!acc) begin failures++; $display("FAIL full_accept n=%0d not accepted, want accepted", n); end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 60 && (e_busy || mq.size() != 0); k++) begin
      cyc();
      checks++;
      if (out_a !== e_a || out_b !== e_b || out_valid !== e_v || in_ready !== e_rdy || busy !== e_busy || done !== e_done)
        begin failures++; $display("FAIL full_drain cyc=%0d a=%h/%h b=%h/%h v=%b/%b rbd=%b%b%b/%b%b%b",
                                   cyc_n, out_a, e_a, out_b, e_b, out_valid, e_v, in_ready, busy, done, e_rdy, e_busy, e_done); end
    end
  endtask

  task automatic test_underrun();
    int nval, gap;
    rst = 1'b0; model_reset(); cyc(); rst = 1'b1; cyc();
    nval = 0; gap = 0;
    for (int k = 0; k < 20; k++) begin
      in_valid = (k == 0 || k == 1 || k == 5);
      in_a = VW'($urandom); in_b = VW'($urandom); in_last = (k == 5);
      cyc();
      if (out_valid[0]) nval++;
      else if (nval == 2) gap++;
      checks++;
      if (out_a !== e_a || out_b !== e_b || out_valid !== e_v || in_ready !== e_rdy || busy !== e_busy ||
          done !== e_done || underrun_cnt !== e_und)
        begin failures++; $display("FAIL underrun_model cyc=%0d a=%h/%h v=%b/%b rbd=%b%b%b/%b%b%b und=%0d/%0d",
                                   cyc_n, out_a, e_a, out_valid, e_v, in_ready, busy, done, e_rdy, e_busy, e_done, underrun_cnt, e_und); end
    end
    in_valid = 1'b0;
    checks++;
    if (nval != 3 || gap != 2) begin failures++; $display("FAIL underrun_gap valid=%0d gap=%0d want 3 and 2", nval, gap); end
    checks++;
`ifdef FEEDER_UNDERRUN_CNT_EN
    if (underrun_cnt !== 8'd2) begin failures++; $display("FAIL underrun_cnt got %0d want 2", underrun_cnt); end
`else
    if (underrun_cnt !== 8'd0) begin failures++; $display("FAIL underrun_cnt got %0d want 0", underrun_cnt); end
`endif
  endtask

  task automatic test_reset_in_flush();
    in_valid = 1'b1; in_a = VW'($urandom); in_b = VW'($urandom); in_last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      in_valid = 1'b0;
    end
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL flush_state busy=%b done=%b want 1 0", busy, done); end
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (out_a !== '0 || out_b !== '0 || out_valid !== '0 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1)
      begin failures++; $display("FAIL flush_reset a=%h b=%h v=%b busy=%b done=%b rdy=%b, want zeros and rdy=1",
                                 out_a, out_b, out_valid, busy, done, in_ready); end
    cyc();
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      checks++;
      if (done !== 1'b0 || out_valid !== '0 || busy !== 1'b0 || in_ready !== 1'b1 || underrun_cnt !== 8'd0)
        begin failures++; $display("FAIL flush_after cyc=%0d done=%b v=%b busy=%b rdy=%b und=%0d want 0 0000 0 1 0",
                                   cyc_n, done, out_valid, busy, in_ready, underrun_cnt); end
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2, nv, l3;
    d1 = -1; d2 = -1; nv = 0; l3 = -1;
    for (int k = 0; k < 24; k++) begin
      in_valid = (k == 0 || k == 1 || k == 5);
      in_a = VW'($urandom); in_b = VW'($urandom); in_last = (k != 0);
      cyc();
      if (out_valid[0]) begin nv++; if (nv == 3) l3 = k; end
      if (done) begin if (d1 < 0) d1 = k; else if (d2 < 0) d2 = k; end
      checks++;
      if (out_a !== e_a || out_b !== e_b || out_valid !== e_v || in_ready !== e_rdy || busy !== e_busy || done !== e_done)
        begin failures++; $display("FAIL b2b_model cyc=%0d a=%h/%h b=%h/%h v=%b/%b rbd=%b%b%b/%b%b%b",
                                   cyc_n, out_a, e_a, out_b, e_b, out_valid, e_v, in_ready, busy, done, e_rdy, e_busy, e_done); end
    end
    in_valid = 1'b0;
    checks++;
    if (d1 != 7 || l3 != 10 || d2 != 14)
      begin failures++; $display("FAIL b2b_timing done1=%0d lane0=%0d done2=%0d want 7 10 14", d1, l3, d2); end
  endtask

  task automatic test_random();
    logic acc;
    for (int k = 0; k < 400; k++) begin
      in_valid = ($urandom_range(0, 99) < 55);
      in_a = VW'($urandom); in_b = VW'($urandom); in_last = ($urandom_range(0, 99) < 20);
      cyc();
      checks++;
      if (out_a !== e_a || out_b !== e_b || out_valid !== e_v || in_ready !== e_rdy || busy !== e_busy ||
          done !== e_done || underrun_cnt !== e_und)
        begin failures++; $display("FAIL random_model cyc=%0d a=%h/%h b=%h/%h v=%b/%b rbd=%b%b%b/%b%b%b und=%0d/%0d",
                                   cyc_n, out_a, e_a, out_b, e_b, out_valid, e_v, in_ready, busy, done, e_rdy, e_busy, e_done, underrun_cnt, e_und); end
    end
    in_valid = 1'b1; in_last = 1'b1; acc = 1'b0;
    for (int k = 0; k < 80 && (!acc || e_busy || mq.size() != 0); k++) begin
      if (!acc) acc = in_ready;
      cyc();
      if (acc) in_valid = 1'b0;
      checks++;
      if (out_a !== e_a || out_b !== e_b || out_valid !== e_v || in_ready !== e_rdy || busy !== e_busy || done !== e_done)
        begin failures++; $display("FAIL random_drain cyc=%0d a=%h/%h v=%b/%b rbd=%b%b%b/%b%b%b",
                                   cyc_n, out_a, e_a, out_valid, e_v, in_ready, busy, done, e_rdy, e_busy, e_done); end
    end
    checks++;
    if (busy !== 1'b0 || e_busy) begin failures++; $display("FAIL random_idle busy=%b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_full();
    test_underrun();
    test_reset_in_flush();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc_n);
    $fatal(1, "watchdog");
  end

endmodule
